sensor_trace_capture: RTL

- Parametrised multi-channel capture engine for on-chip delay-sensor (TDC) samples. Generalises the fixed 2048-sample, single-channel, post-trigger-only sensor loop.
- Buffers CH_COUNT channels in a circular RAM with programmable decimation and a pre-trigger window.
- After capture, streams the trace as bytes over a valid/ready interface that feeds the UART TX.

---
 rtl/sensor_trace_capture_if.sv | 9 +
 rtl/sensor_trace_capture.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_trace_capture_if.sv
// Byte stream from the sensor trace capture engine towards the UART transmitter.
interface sensor_trace_capture_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (output tx_data_o, output tx_valid_o, input tx_ready_i);
    modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_i);
endinterface

// File: rtl/sensor_trace_capture.sv
// Multi-channel TDC sample capture: decimation, pre-trigger window, circular RAM, byte dump.
// Define SENSOR_TRACE_HEADER_EN to prepend a 4-byte header to every dump.
module sensor_trace_capture #(
    parameter int CH_COUNT = 1,
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 2048,
    parameter int PRETRIG  = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CH_COUNT*SAMPLE_W-1:0] sample_i,
    input  logic                         sample_vld_i,
    input  logic [3:0]                   dec_i,
    input  logic                         arm_i,
    input  logic                         trig_i,
    input  logic                         abort_i,
    sensor_trace_capture_if.master       tx,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int WW = CH_COUNT * SAMPLE_W;

    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   PRE_N    = (AW+1)'(PRETRIG);
    localparam logic [AW:0]   POST_N   = (AW+1)'(DEPTH - PRETRIG);
    localparam logic [AW:0]   DEPTH_N  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PRE_PTR  = AW'(PRETRIG);
    localparam logic [CW-1:0] CH_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CH_ONE   = CW'(1);
    localparam logic [CW-1:0] LAST_CH  = CW'(CH_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DUMP    = 3'd3,
        S_WRAP    = 3'd4
    } state_t;

    function automatic logic [7:0] lane_byte(input logic [WW-1:0] word, input logic [CW-1:0] ch);
        logic [7:0] b;
        b = 8'd0;
        b[SAMPLE_W-1:0] = word[int'(ch)*SAMPLE_W +: SAMPLE_W];
        return b;
    endfunction

`ifdef SENSOR_TRACE_HEADER_EN
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        logic [15:0] pre;
        logic [7:0]  b;
        pre = 16'(PRETRIG);
        case (idx)
            2'd0:    b = 8'hA5;
            2'd1:    b = 8'(CH_COUNT);
            2'd2:    b = pre[15:8];
            2'd3:    b = pre[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [2:0]    hdr_r;
    logic [2:0]    hdr_nxt_s;
`endif

    state_t        state_r, state_nxt_s;
    logic [3:0]    dec_r, dec_nxt_s;
    logic [3:0]    dec_cnt_r, dec_cnt_nxt_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [AW:0]   fill_r, fill_nxt_s;
    logic [AW:0]   post_r, post_nxt_s;
    logic [AW-1:0] start_ptr_r, start_nxt_s;
    logic [AW:0]   ld_s_r, ld_s_nxt_s;
    logic [CW-1:0] ld_c_r, ld_c_nxt_s;
    logic [7:0]    tx_data_r, tx_data_nxt_s;
    logic          tx_valid_r, tx_valid_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          done_r, done_nxt_s;
    logic          acc_s, store_s, wr_en_s, ld_en_s;
    logic [AW-1:0] rd_addr_s;
    logic [WW-1:0] rd_data_r;
    logic [WW-1:0] mem_r [DEPTH];

    // Next-state and datapath control for the capture/dump sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        dec_nxt_s      = dec_r;
        dec_cnt_nxt_s  = dec_cnt_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        fill_nxt_s     = fill_r;
        post_nxt_s     = post_r;
        start_nxt_s    = start_ptr_r;
        ld_s_nxt_s     = ld_s_r;
        ld_c_nxt_s     = ld_c_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        wr_en_s        = 1'b0;
`ifdef SENSOR_TRACE_HEADER_EN
        hdr_nxt_s      = hdr_r;
`endif
        acc_s   = sample_vld_i && (dec_cnt_r == dec_r);
        store_s = (state_r == S_ARMED) || ((state_r == S_CAPTURE) && (post_r != POST_N));
        ld_en_s = !tx_valid_r || tx.tx_ready_i;

        // Skipped valid samples still advance the decimation phase.
        if (store_s && acc_s) begin
            wr_en_s       = 1'b1;
            wr_ptr_nxt_s  = wr_ptr_r + PTR_ONE;
            dec_cnt_nxt_s = 4'd0;
        end else if (store_s && sample_vld_i) begin
            dec_cnt_nxt_s = dec_cnt_r + 4'd1;
        end else begin
            wr_en_s = 1'b0;
        end

        case (state_r)
            S_IDLE: begin
                ld_s_nxt_s = CNT_ZERO;
                ld_c_nxt_s = CH_ZERO;
`ifdef SENSOR_TRACE_HEADER_EN
                hdr_nxt_s  = 3'd0;
`endif
                if (arm_i) begin
                    state_nxt_s   = S_ARMED;
                    dec_nxt_s     = dec_i;
                    dec_cnt_nxt_s = 4'd0;
                    wr_ptr_nxt_s  = PTR_ZERO;
                    fill_nxt_s    = CNT_ZERO;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ARMED: begin
                // fill saturates at PRETRIG, so equality means the window is full.
                if (trig_i && (fill_r == PRE_N)) begin
                    state_nxt_s = S_CAPTURE;
                    start_nxt_s = wr_ptr_r - PRE_PTR;
                    post_nxt_s  = acc_s ? CNT_ONE : CNT_ZERO;
                end else begin
                    state_nxt_s = S_ARMED;
                end
                if (acc_s && (fill_r != PRE_N)) begin
                    fill_nxt_s = fill_r + CNT_ONE;
                end else begin
                    fill_nxt_s = fill_r;
                end
            end
            S_CAPTURE: begin
                if (post_r == POST_N) begin
                    state_nxt_s = S_DUMP;
                end else if (acc_s) begin
                    post_nxt_s = post_r + CNT_ONE;
                end else begin
                    post_nxt_s = post_r;
                end
            end
            S_DUMP: begin
                if (tx_valid_r && tx.tx_ready_i && (ld_s_r == DEPTH_N)) begin
                    state_nxt_s    = S_WRAP;
                    tx_valid_nxt_s = 1'b0;
                end else if (ld_en_s) begin
`ifdef SENSOR_TRACE_HEADER_EN
                    if (hdr_r != 3'd4) begin
                        tx_data_nxt_s  = hdr_byte(hdr_r[1:0]);
                        tx_valid_nxt_s = 1'b1;
                        hdr_nxt_s      = hdr_r + 3'd1;
                    end else
`endif
                    if (ld_s_r != DEPTH_N) begin
                        tx_data_nxt_s  = lane_byte(rd_data_r, ld_c_r);
                        tx_valid_nxt_s = 1'b1;
                        if (ld_c_r == LAST_CH) begin
                            ld_c_nxt_s = CH_ZERO;
                            ld_s_nxt_s = ld_s_r + CNT_ONE;
                        end else begin
                            ld_c_nxt_s = ld_c_r + CH_ONE;
                        end
                    end else begin
                        tx_valid_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = S_DUMP;
                end
            end
            S_WRAP: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s    = S_IDLE;
                tx_valid_nxt_s = 1'b0;
            end
        endcase

        if (abort_i) begin
            state_nxt_s    = S_IDLE;
            tx_valid_nxt_s = 1'b0;
            wr_en_s        = 1'b0;
        end else begin
            tx_valid_nxt_s = tx_valid_nxt_s & (state_nxt_s == S_DUMP);
        end

        busy_nxt_s = (state_nxt_s != S_IDLE);
        done_nxt_s = (state_nxt_s == S_WRAP);
        // Address follows the sample that will be needed by the next load.
        rd_addr_s  = start_ptr_r + ld_s_nxt_s[AW-1:0];
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            dec_r       <= 4'd0;
            dec_cnt_r   <= 4'd0;
            wr_ptr_r    <= PTR_ZERO;
            fill_r      <= CNT_ZERO;
            post_r      <= CNT_ZERO;
            start_ptr_r <= PTR_ZERO;
            ld_s_r      <= CNT_ZERO;
            ld_c_r      <= CH_ZERO;
            tx_data_r   <= 8'd0;
            tx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SENSOR_TRACE_HEADER_EN
            hdr_r       <= 3'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            dec_r       <= dec_nxt_s;
            dec_cnt_r   <= dec_cnt_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            fill_r      <= fill_nxt_s;
            post_r      <= post_nxt_s;
            start_ptr_r <= start_nxt_s;
            ld_s_r      <= ld_s_nxt_s;
            ld_c_r      <= ld_c_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            tx_valid_r  <= tx_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
`ifdef SENSOR_TRACE_HEADER_EN
            hdr_r       <= hdr_nxt_s;
`endif
        end
    end

    // Trace RAM: one write port for all lanes, one synchronous read port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= sample_i;
        end
        rd_data_r <= mem_r[rd_addr_s];
    end

    assign tx.tx_data_o  = tx_data_r;
    assign tx.tx_valid_o = tx_valid_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;

endmodule
